// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the single main-memory port.
// Each transaction holds the port for MEM_LATENCY cycles, then pulses the granted requester's ready.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in  [0:3],
    input  logic [7:0]  mem_data_out [0:3],
    output logic        mem_write_en,
    output logic        busy
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic {G_IF = 1'b0, G_D = 1'b1} grant_t;

    state_t           r_state;
    grant_t           r_last;
    grant_t           r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_if_data;
    logic [31:0]      r_d_rdata;
    logic             r_we;
    logic             r_wen;
    logic             r_if_ready;
    logic             r_d_ready;
    logic             r_busy;

    logic             w_grant_d;
    logic [31:0]      w_rdata;

    // On a tie the requester that did not win last time is served.
    assign w_grant_d = d_req && (!if_req || (r_last == G_IF));
    assign w_rdata   = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_last     <= G_IF;
            r_owner    <= G_IF;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_data  <= '0;
            r_d_rdata  <= '0;
            r_we       <= 1'b0;
            r_wen      <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_wen      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        r_owner <= w_grant_d ? G_D : G_IF;
                        r_last  <= w_grant_d ? G_D : G_IF;
                        r_addr  <= w_grant_d ? d_addr : if_addr;
                        r_we    <= w_grant_d && d_we;
                        r_wdata <= d_wdata;
                        r_cnt   <= CNT_LOAD;
                        // With a one-cycle access the first BUSY cycle is also the last.
                        r_wen   <= (MEM_LATENCY == 1) && w_grant_d && d_we;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner == G_D) r_d_rdata <= w_rdata;
                            else                r_if_data <= w_rdata;
                        end
                        r_if_ready <= (r_owner == G_IF);
                        r_d_ready  <= (r_owner == G_D);
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                        r_wen <= (r_cnt == CNT_ONE) && r_we;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ready       = r_if_ready;
    assign if_data        = r_if_data;
    assign d_ready        = r_d_ready;
    assign d_rdata        = r_d_rdata;
    assign mem_addr       = r_addr;
    assign mem_write_en   = r_wen;
    assign busy           = r_busy;
    assign mem_data_in[0] = r_wdata[31:24];
    assign mem_data_in[1] = r_wdata[23:16];
    assign mem_data_in[2] = r_wdata[15:8];
    assign mem_data_in[3] = r_wdata[7:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a MEM_LATENCY=4 and a MEM_LATENCY=1 arbiter with shared stimulus and checks both
// against a transaction-timeline model, plus hand-computed expectations for the directed cases.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic [1:0]  busy_o, wen_o, ifr_o, dr_o;
    logic [31:0] ifd_o [2];
    logic [31:0] drd_o [2];
    logic [31:0] ma_o  [2];
    logic [31:0] mdi_p [2];
    logic [7:0]  mdi0 [0:3];
    logic [7:0]  mdi1 [0:3];
    logic [7:0]  mdo0 [0:3];
    logic [7:0]  mdo1 [0:3];

    logic [31:0] dmem [2][256];
    logic [31:0] mm   [2][256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter #(.MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req), .if_addr(if_addr), .if_ready(ifr_o[0]), .if_data(ifd_o[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(dr_o[0]), .d_rdata(drd_o[0]),
        .mem_addr(ma_o[0]), .mem_data_in(mdi0), .mem_data_out(mdo0),
        .mem_write_en(wen_o[0]), .busy(busy_o[0])
    );

    mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req), .if_addr(if_addr), .if_ready(ifr_o[1]), .if_data(ifd_o[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(dr_o[1]), .d_rdata(drd_o[1]),
        .mem_addr(ma_o[1]), .mem_data_in(mdi1), .mem_data_out(mdo1),
        .mem_write_en(wen_o[1]), .busy(busy_o[1])
    );

    assign mdi_p[0] = {mdi0[0], mdi0[1], mdi0[2], mdi0[3]};
    assign mdi_p[1] = {mdi1[0], mdi1[1], mdi1[2], mdi1[3]};
    assign mdo0[0] = dmem[0][ma_o[0][9:2]][31:24];
    assign mdo0[1] = dmem[0][ma_o[0][9:2]][23:16];
    assign mdo0[2] = dmem[0][ma_o[0][9:2]][15:8];
    assign mdo0[3] = dmem[0][ma_o[0][9:2]][7:0];
    assign mdo1[0] = dmem[1][ma_o[1][9:2]][31:24];
    assign mdo1[1] = dmem[1][ma_o[1][9:2]][23:16];
    assign mdo1[2] = dmem[1][ma_o[1][9:2]][15:8];
    assign mdo1[3] = dmem[1][ma_o[1][9:2]][7:0];

    // Memory model: one word per address[9:2], committed on the write strobe.
    always @(posedge clk) begin
        if (wen_o[0]) dmem[0][ma_o[0][9:2]] <= mdi_p[0];
        if (wen_o[1]) dmem[1][ma_o[1][9:2]] <= mdi_p[1];
    end

    task automatic chk32(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @cyc %0d: got %h, expected %h", nm, inst, cyc, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input int inst, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @cyc %0d: got %b, expected %b", nm, inst, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a transaction granted in cycle g occupies cycles g+1..g+L,
    // writes/captures at the end of g+L, and signals ready in g+L+1.
    bit          m_act  [2];
    int          m_g    [2];
    bit          m_own_d[2];
    bit          m_we   [2];
    bit          m_last_d[2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_if   [2];
    logic [31:0] m_d    [2];
    int          lat;
    logic        e_busy, e_wen, e_ifr, e_dr, gd;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 4 : 1;
            if (!rst_b) begin
                m_act[i]    = 1'b0;
                m_last_d[i] = 1'b0;
                m_addr[i]   = '0;
                m_wd[i]     = '0;
                m_if[i]     = '0;
                m_d[i]      = '0;
            end
            e_busy = m_act[i] && (cyc > m_g[i]) && (cyc <= m_g[i] + lat + 1);
            e_wen  = m_act[i] && (cyc == m_g[i] + lat) && m_we[i];
            e_ifr  = m_act[i] && (cyc == m_g[i] + lat + 1) && !m_own_d[i];
            e_dr   = m_act[i] && (cyc == m_g[i] + lat + 1) && m_own_d[i];
            chk1("busy", i, busy_o[i], e_busy);
            chk1("mem_write_en", i, wen_o[i], e_wen);
            chk1("if_ready", i, ifr_o[i], e_ifr);
            chk1("d_ready", i, dr_o[i], e_dr);
            chk32("mem_addr", i, ma_o[i], m_addr[i]);
            chk32("mem_data_in", i, mdi_p[i], m_wd[i]);
            chk32("if_data", i, ifd_o[i], m_if[i]);
            chk32("d_rdata", i, drd_o[i], m_d[i]);
            if (rst_b) begin
                if (m_act[i] && (cyc == m_g[i] + lat)) begin
                    if (m_we[i])        mm[i][m_addr[i][9:2]] = m_wd[i];
                    else if (m_own_d[i]) m_d[i] = mm[i][m_addr[i][9:2]];
                    else                 m_if[i] = mm[i][m_addr[i][9:2]];
                end
                if ((!m_act[i] || (cyc > m_g[i] + lat + 1)) && (if_req || d_req)) begin
                    gd          = d_req && (!if_req || !m_last_d[i]);
                    m_act[i]    = 1'b1;
                    m_g[i]      = cyc;
                    m_own_d[i]  = gd;
                    m_last_d[i] = gd;
                    m_we[i]     = gd && d_we;
                    m_addr[i]   = gd ? d_addr : if_addr;
                    m_wd[i]     = d_wdata;
                end
            end
        end
    end

    initial begin
        rst_b = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 256; k++) begin
            dmem[0][k] = 32'hA500_0000 | k;
            dmem[1][k] = 32'hA500_0000 | k;
            mm[0][k]   = 32'hA500_0000 | k;
            mm[1][k]   = 32'hA500_0000 | k;
        end
        for (int i = 0; i < 2; i++) begin
            dmem[i][16] = 32'h1234_5678;  mm[i][16] = 32'h1234_5678;
            dmem[i][64] = 32'h1111_1111;  mm[i][64] = 32'h1111_1111;
        end

        repeat (3) tick();
        chk1("rst_busy", 0, busy_o[0], 1'b0);
        chk32("rst_mem_addr", 0, ma_o[0], 32'h0);
        chk32("rst_if_data", 1, ifd_o[1], 32'h0);
        rst_b = 1'b1;
        tick();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 5) chk1("fetch_busy", 0, busy_o[0], 1'b1);
            if (k <= 5) chk1("fetch_wen", 0, wen_o[0], 1'b0);
            if (k == 4) chk32("fetch_addr", 0, ma_o[0], 32'h40);
            if (k == 4) chk1("fetch_early_ready", 0, ifr_o[0], 1'b0);
            if (k == 5) chk1("fetch_ready", 0, ifr_o[0], 1'b1);
            if (k == 5) chk32("fetch_data", 0, ifd_o[0], 32'h1234_5678);
            if (k == 2) chk1("fetch_ready_l1", 1, ifr_o[1], 1'b1);
            if (k == 2) chk32("fetch_data_l1", 1, ifd_o[1], 32'h1234_5678);
            if (k == 3) chk1("regrant_idle_l1", 1, busy_o[1], 1'b0);
            if (k == 4) chk1("regrant_busy_l1", 1, busy_o[1], 1'b1);
            if (k == 6) chk1("fetch_idle", 0, busy_o[0], 1'b0);
            if (k == 5) if_req = 1'b0;
        end

        // Data write then read of the same address
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 5) chk1("wr_wen", 0, wen_o[0], k == 4);
            if (k == 4) chk32("wr_bytes", 0, mdi_p[0], 32'hDEAD_BEEF);
            if (k == 2) chk1("wr_ready_l1", 1, dr_o[1], 1'b1);
            if (k == 5) chk1("wr_ready", 0, dr_o[0], 1'b1);
            if (k == 10) chk1("rd_early_ready", 0, dr_o[0], 1'b0);
            if (k == 11) chk1("rd_ready", 0, dr_o[0], 1'b1);
            if (k == 11) chk32("rd_data", 0, drd_o[0], 32'hDEAD_BEEF);
            if (k == 5) d_we = 1'b0;
            if (k == 11) d_req = 1'b0;
        end

        // Both requesters held from reset release
        rst_b = 1'b0;
        tick(); tick();
        rst_b = 1'b1;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 5)  chk1("tie_d1", 0, dr_o[0], 1'b1);
            if (k == 5)  chk32("tie_d1_data", 0, drd_o[0], 32'hDEAD_BEEF);
            if (k == 11) chk1("tie_if1", 0, ifr_o[0], 1'b1);
            if (k == 11) chk1("tie_if1_not_d", 0, dr_o[0], 1'b0);
            if (k == 17) chk1("tie_d2", 0, dr_o[0], 1'b1);
            if (k == 23) chk1("tie_if2", 0, ifr_o[0], 1'b1);
            if (k == 5)  chk1("tie_if1_l1", 1, ifr_o[1], 1'b1);
            if (k == 24) begin if_req = 1'b0; d_req = 1'b0; end
        end

        // Reset in the second BUSY cycle of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        tick(); tick();
        rst_b = 1'b0; d_req = 1'b0;
        #1;
        chk1("rstmid_busy", 0, busy_o[0], 1'b0);
        chk1("rstmid_wen", 0, wen_o[0], 1'b0);
        chk32("rstmid_addr", 0, ma_o[0], 32'h0);
        chk32("rstmid_wdata", 0, mdi_p[0], 32'h0);
        chk32("rstmid_if_data", 0, ifd_o[0], 32'h0);
        chk32("rstmid_d_rdata", 0, drd_o[0], 32'h0);
        tick(); tick();
        rst_b = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 5) chk1("rstmid_no_dready", 0, dr_o[0], 1'b0);
            if (k == 5) chk1("post_rst_if_ready", 0, ifr_o[0], 1'b1);
            if (k == 5) if_req = 1'b0;
        end
        chk32("rstmid_mem_kept", 0, dmem[0][64], 32'h1111_1111);

        // Request dropped while BUSY
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick();
        d_req = 1'b0;
        chk1("drop_busy", 0, busy_o[0], 1'b1);
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (k == 2) chk1("drop_ready_l1", 1, dr_o[1], 1'b1);
            if (k == 2) chk32("drop_data_l1", 1, drd_o[1], 32'h1234_5678);
            if (k == 5) chk1("drop_ready", 0, dr_o[0], 1'b1);
            if (k == 5) chk32("drop_data", 0, drd_o[0], 32'h1234_5678);
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_b   = ($urandom_range(0, 199) != 0);
            if_req  = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = ($urandom_range(0, 1) != 0);
            if_addr = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        rst_b = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) begin
                chk32("mem_image", i, dmem[i][k], mm[i][k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
